instr_fetch_unit: RTL and testbench

//  Front end of the SISA pipeline: produces the instruction stream consumed by decode (the instr_if/instr_de stages).

---
 rtl/sisa_fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisa_fetch_pkg.sv
// Shared types and constants for the SISA instruction fetch front end.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sisa_fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam int INSTR_BYTES  = 4;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, instr} entries between the memory response path and decode.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: the producer must not push into a full, unpopped FIFO; flush empties it and overrides push.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write one entry
//   pop                 remove the head (ignored when empty)
//   flush               discard all entries this cycle
//   head, head_valid    oldest entry and its valid flag
//   count               number of entries held
module fetch_fifo
  import sisa_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Storage needs no reset: count gates visibility of every slot.
  // Push-while-full-and-popping writes the slot the head is leaving.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && (count == FULL_CNT) && !pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential Avalon-MM reads into a prefetch FIFO, {pc, instr} out to decode.
// Latency: first instr_valid 3 cycles after BOOT with a zero-wait memory; one instruction per cycle sustained.
// Backpressure: reads issue only while buffered + in-flight words < DEPTH, so decode stalls never overflow the FIFO.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   reset_vector_addr                boot PC, taken in the BOOT cycle
//   redirect_valid, redirect_addr    taken branch/jump from EX (low 2 address bits ignored)
//   avm_*                            Avalon-MM pipelined read master
//   instr_valid/ready, instr_data/pc FIFO head toward decode
//   halted                           HALT_INSTR was buffered; no further issues
module instr_fetch_unit
  import sisa_fetch_pkg::*;
#(
  parameter int              ADDR_W     = FETCH_ADDR_W,
  parameter int              DATA_W     = FETCH_DATA_W,
  parameter int              DEPTH      = 4,
  parameter logic [DATA_W-1:0] HALT_INSTR = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] reset_vector_addr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              halted
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]    CREDIT_LIMIT = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP      = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] WORD_MASK    = ~ADDR_W'(INSTR_BYTES-1);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] held_addr;
  logic              held_vld;
  logic              held_stale;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_nxt;
  logic [CNT_W-1:0]  discard_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_sum;
  logic              issue_ok;
  logic              accept;
  logic              rdv;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // Credit uses registered counts only, keeping avm_read free of input-to-output paths.
  assign credit_sum = {1'b0, fifo_count} + {1'b0, outstanding};
  assign issue_ok   = (state == RUN) && (credit_sum < CREDIT_LIMIT);

  // A stalled request is replayed from held_addr so the bus stays stable even if
  // fetch_pc moves (redirect) or issuing stops (HALT) while waitrequest is high.
  assign avm_read    = held_vld | issue_ok;
  assign avm_address = held_vld ? held_addr : fetch_pc;

  assign accept = avm_read & ~avm_waitrequest;
  // Ignore strobes with nothing in flight (e.g. a response racing a reset).
  assign rdv    = avm_readdatavalid & (outstanding != '0);
  assign push   = rdv & ~redirect_valid & (discard_cnt == '0);
  assign pop    = instr_valid & instr_ready;

  assign outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(rdv);

  assign push_entry = '{pc: resp_pc, instr: avm_readdata};

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (push && (avm_readdata == HALT_INSTR)) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
    if (redirect_valid) state_nxt = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= '0;
      resp_pc     <= '0;
      held_addr   <= '0;
      held_vld    <= 1'b0;
      held_stale  <= 1'b0;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      held_vld    <= avm_read & avm_waitrequest;
      held_addr   <= avm_address;
      // A request stalled across a redirect belongs to the old stream.
      held_stale  <= avm_read & avm_waitrequest & (redirect_valid | held_stale);
      if (redirect_valid) begin
        fetch_pc    <= redirect_addr & WORD_MASK;
        resp_pc     <= redirect_addr & WORD_MASK;
        // Everything still in flight after this cycle is from the old stream.
        discard_cnt <= outstanding_nxt;
      end else if (state == BOOT) begin
        fetch_pc <= reset_vector_addr & WORD_MASK;
        resp_pc  <= reset_vector_addr & WORD_MASK;
      end else begin
        // A stale replay completes without advancing the new stream's PC,
        // and its response joins the discard count.
        if (accept && !held_stale) fetch_pc <= fetch_pc + PC_STEP;
        if (push)                  resp_pc  <= resp_pc + PC_STEP;
        discard_cnt <= discard_cnt + CNT_W'(accept & held_stale)
                                   - CNT_W'(rdv & (discard_cnt != '0));
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .head_valid (instr_valid),
    .count      (fifo_count)
  );

  assign instr_pc   = head.pc;
  assign instr_data = head.instr;
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: Avalon memory model, scoreboard of the expected instruction stream.
// Latency: n/a.
// Backpressure: decode ready and memory waitrequest are driven directed and randomly.
module tb_instr_fetch_unit;
  import sisa_fetch_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] HALT_W = 32'h0000_0001;
  localparam logic [31:0] NO_PC  = 32'hDEAD_BEE1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] reset_vector_addr = 32'h100;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;
  logic        halted;

  instr_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .HALT_INSTR(HALT_W)
  ) dut (
    .clk(clk), .reset(reset), .reset_vector_addr(reset_vector_addr),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check1(string name, logic got, logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t        pend[$];
  logic [31:0] acc_log[$];
  int          cyc = 0;
  int          mem_lat = 1;
  int          wait_pct = 0;
  bit          force_wait = 0;
  bit          stall_en = 0;
  logic [31:0] stall_addr = '0;
  logic [31:0] halt_addr = 32'hFFFF_FFFF;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == halt_addr) return HALT_W;
    return {a[15:0], ~a[15:0]};
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      avm_readdatavalid = 1'b0;
      if (reset) pend.delete();
      else if (pend.size() > 0 && pend[0].due <= cyc) begin
        avm_readdata      = mem_word(pend[0].addr);
        avm_readdatavalid = 1'b1;
        void'(pend.pop_front());
      end
      avm_waitrequest = force_wait || (wait_pct > 0 && $urandom_range(99) < wait_pct)
                        || (stall_en && avm_address == stall_addr);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && avm_read && !avm_waitrequest) begin
        pend.push_back('{addr: avm_address, due: cyc + mem_lat});
        acc_log.push_back(avm_address);
      end
    end
  end

  // ---------------- scoreboard ----------------
  fetch_entry_t exp_q[$];
  fetch_entry_t e;
  int           pop_cnt = 0;
  logic [31:0]  last_pc = '0;
  bit           saw_halt = 0;
  bit           prev_stall = 0;
  bit           prev_hold = 0;
  logic [31:0]  prev_addr = '0;
  logic [31:0]  prev_pc = '0;
  logic [31:0]  prev_data = '0;

  // The architectural stream from a start PC: consecutive words, wrapping at 2^32.
  function automatic void push_stream(logic [31:0] start);
    logic [31:0] pc;
    pc = start & 32'hFFFF_FFFC;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{pc: pc, instr: mem_word(pc)});
      pc += 32'd4;
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
        prev_hold  = 0;
      end else begin
        if (prev_stall) begin
          check1("avm_hold_read", avm_read, 1'b1);
          check32("avm_hold_addr", avm_address, prev_addr);
        end
        if (prev_hold) begin
          check1("instr_hold_valid", instr_valid, 1'b1);
          check32("instr_hold_pc", instr_pc, prev_pc);
          check32("instr_hold_data", instr_data, prev_data);
        end
        if (halted) check1("halt_no_issue", avm_read & ~prev_stall, 1'b0);
        if (avm_read) check32("avm_align", {30'd0, avm_address[1:0]}, 32'd0);
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: popped pc 0x%08h with nothing expected", instr_pc);
          end else begin
            e = exp_q.pop_front();
            check32("sb_pc", instr_pc, e.pc);
            check32("sb_instr", instr_data, e.instr);
          end
          if (instr_data == HALT_W) saw_halt = 1;
          pop_cnt++;
          last_pc = instr_pc;
        end
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
        prev_hold  = instr_valid && !instr_ready && !redirect_valid;
        prev_pc    = instr_pc;
        prev_data  = instr_data;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset(logic [31:0] vec);
    @(posedge clk); #1;
    reset = 1'b1;
    reset_vector_addr = vec;
    #1;
    check1("rst_avm_read", avm_read, 1'b0);
    check32("rst_avm_addr", avm_address, 32'd0);
    check1("rst_instr_valid", instr_valid, 1'b0);
    check1("rst_halted", halted, 1'b0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    push_stream(vec);
    reset = 1'b0;
  endtask

  task automatic do_redirect(logic [31:0] addr);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    @(negedge clk); #1;
    push_stream(addr);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check1("flush_valid", instr_valid, 1'b0);
    check1("redir_halted", halted, 1'b0);
  endtask

  task automatic wait_pop(output logic [31:0] pc);
    int start;
    start = pop_cnt;
    pc = NO_PC;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (pop_cnt != start) begin
        pc = last_pc;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  int          lat;
  int          cnt;
  int          last_redir;
  bit          found;
  logic [31:0] pc;
  logic [31:0] ra;

  initial begin
    // 1: boot latency and sustained streaming
    apply_reset(32'h100);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      if (instr_valid) break;
      lat++;
    end
    check32("first_latency", 32'(lat), 32'd3);
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (instr_valid) cnt++;
    end
    check32("stream_no_gaps", 32'(cnt), 32'd16);

    // 2: decode stalled -> exactly DEPTH buffered
    instr_ready = 1'b0;
    apply_reset(32'h100);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check1("full_no_read", avm_read, 1'b0);
    @(posedge clk); #1;
    force_wait  = 1;
    instr_ready = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (instr_valid) cnt++;
    end
    check32("buffered_count", 32'(cnt), 32'(DEPTH));
    force_wait = 0;

    // 3: redirect with reads in flight behind a 3-cycle memory
    mem_lat = 3;
    apply_reset(32'h100);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #1;
      if (pend.size() >= 2) found = 1;
    end
    check1("wait_inflight2", found, 1'b1);
    do_redirect(32'h200);
    wait_pop(pc);
    check32("redir_first_pc", pc, 32'h200);

    // 4: redirect while a request is stalled
    mem_lat    = 1;
    stall_addr = 32'h110;
    stall_en   = 1;
    apply_reset(32'h100);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (avm_read && avm_address == 32'h110) found = 1;
    end
    check1("wait_x110", found, 1'b1);
    acc_log.delete();
    repeat (3) @(posedge clk);
    do_redirect(32'h300);
    check1("stale_read", avm_read, 1'b1);
    check32("stale_addr", avm_address, 32'h110);
    @(posedge clk); #1;
    stall_en = 0;
    for (int i = 0; i < 20 && acc_log.size() < 2; i++) @(negedge clk);
    check32("acc_count", 32'(acc_log.size() >= 2), 32'd1);
    if (acc_log.size() >= 2) begin
      check32("acc_stale", acc_log[0], 32'h110);
      check32("acc_new", acc_log[1], 32'h300);
    end
    wait_pop(pc);
    check32("redir_wait_pc", pc, 32'h300);

    // 5: halt word, drain, redirect out of HALT
    halt_addr = 32'h40C;
    saw_halt  = 0;
    apply_reset(32'h400);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (halted) found = 1;
    end
    check1("halt_seen", found, 1'b1);
    repeat (20) @(negedge clk);
    check1("halt_drained", instr_valid, 1'b0);
    check1("halt_idle_bus", avm_read, 1'b0);
    check1("halt_sticky", halted, 1'b1);
    check1("halt_word_popped", saw_halt, 1'b1);
    halt_addr = 32'hFFFF_FFFF;
    do_redirect(32'h000);
    wait_pop(pc);
    check32("resume_pc", pc, 32'h000);

    // 6: reset with reads in flight
    mem_lat = 3;
    apply_reset(32'h100);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #1;
      if (pend.size() >= 3) found = 1;
    end
    check1("wait_inflight3", found, 1'b1);
    apply_reset(32'h180);
    wait_pop(pc);
    check32("reboot_pc", pc, 32'h180);

    // Random: decode stalls, bus stalls, latencies, redirects (incl. wrap and unaligned)
    wait_pct   = 25;
    last_redir = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      instr_ready = ($urandom_range(3) != 0);
      if ($urandom_range(99) < 3 || c - last_redir > 150) begin
        if ($urandom_range(7) == 0) ra = 32'hFFFF_FFF0 | ($urandom & 32'h3);
        else                        ra = $urandom & 32'h0000_FFFF;
        mem_lat    = $urandom_range(4, 1);
        last_redir = c;
        do_redirect(ra);
      end
    end
    wait_pct    = 0;
    instr_ready = 1'b1;
    repeat (20) @(negedge clk);
    check1("final_streaming", instr_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
